// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with a memory ready handshake.
// Only IRWrite/PCWrite in FETCH look at mem_ready; every other output is a pure function of state.
module multicycle_control #(
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     cur, nxt;
    logic       funct_ok;
    logic [2:0] funct_alu;

    assign state = cur;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b000;
        case (Funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt        = FETCH;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = 3'b000;
        illegal    = 1'b0;
        case (cur)
            FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                // rst_n gating keeps the enables quiet while reset holds us in FETCH
                IRWrite    = mem_ready & rst_n;
                PCWrite    = mem_ready & rst_n;
                nxt        = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b010;
                case (Op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = funct_ok ? EXECUTE : ILLEGAL;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = EN_ADDI ? ADDIEX : ILLEGAL;
                    OP_J:         nxt = EN_JUMP ? JUMP : ILLEGAL;
                    default:      nxt = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                nxt        = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD = 1'b1;
                nxt  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                nxt        = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                Branch     = 1'b1;
                PCSrc      = 2'b01;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
                nxt        = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            ILLEGAL: begin
                illegal = 1'b1;
                nxt     = ILLEGAL;
            end
            default: nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench: a default instance and an instance with addi/j disabled, checked every cycle against
// an instruction-plan model, plus directed literal checks of the key scenarios.
module tb_multicycle_control;
    typedef struct packed {
        logic       iord, irw, memw, pcw, br;
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb;
        logic       regdst, m2r, regw;
        logic [2:0] aluc;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        logic [3:0]  cur;
        logic [15:0] seq;
        logic [3:0]  len;
    } mstate_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [5:0] op = LW, funct = 6'b100000;
    logic mem_ready = 1'b1;

    logic [1:0] iord, irw, memw, pcw, br, srca, regdst, m2r, regw, ill;
    logic [1:0][1:0] pcsrc, srcb;
    logic [1:0][2:0] aluc;
    logic [1:0][3:0] st;

    int n_tests = 0;
    int n_fail  = 0;
    mstate_t m[2];
    bit ea[2] = '{1'b1, 1'b0};
    bit ej[2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    multicycle_control dut0 (
        .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .mem_ready(mem_ready),
        .IorD(iord[0]), .IRWrite(irw[0]), .MemWrite(memw[0]), .PCWrite(pcw[0]),
        .Branch(br[0]), .PCSrc(pcsrc[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]),
        .RegDst(regdst[0]), .MemtoReg(m2r[0]), .RegWrite(regw[0]),
        .ALUControl(aluc[0]), .illegal(ill[0]), .state(st[0])
    );

    multicycle_control #(.EN_ADDI(1'b0), .EN_JUMP(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .mem_ready(mem_ready),
        .IorD(iord[1]), .IRWrite(irw[1]), .MemWrite(memw[1]), .PCWrite(pcw[1]),
        .Branch(br[1]), .PCSrc(pcsrc[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]),
        .RegDst(regdst[1]), .MemtoReg(m2r[1]), .RegWrite(regw[1]),
        .ALUControl(aluc[1]), .illegal(ill[1]), .state(st[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] funct_code(input logic [5:0] f, output bit ok);
        ok = 1'b1;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin ok = 1'b0; return 3'b000; end
        endcase
    endfunction

    // Remaining states an instruction walks after DECODE, packed as nibbles, first in the low nibble.
    function automatic mstate_t plan(input logic [5:0] o, input logic [5:0] f, input bit a, input bit j);
        mstate_t p = '0;
        bit ok;
        logic [2:0] unused_code;
        unused_code = funct_code(f, ok);
        if (o == LW)                  begin p.seq = 16'h0432; p.len = 4'd3; end
        else if (o == SW)             begin p.seq = 16'h0052; p.len = 4'd2; end
        else if (o == RT && ok)       begin p.seq = 16'h0076; p.len = 4'd2; end
        else if (o == BEQ)            begin p.seq = 16'h0008; p.len = 4'd1; end
        else if (o == ADDI && a)      begin p.seq = 16'h00A9; p.len = 4'd2; end
        else if (o == JMP && j)       begin p.seq = 16'h000B; p.len = 4'd1; end
        else                          begin p.seq = 16'h000F; p.len = 4'd1; end
        return p;
    endfunction

    function automatic mstate_t mnext(input mstate_t s, input bit a, input bit j,
                                      input logic [5:0] o, input logic [5:0] f, input bit mr);
        mstate_t n = s;
        if (s.cur == 4'd15) return s;
        if ((s.cur == 4'd0 || s.cur == 4'd3 || s.cur == 4'd5) && !mr) return s;
        if (s.cur == 4'd0) begin n.cur = 4'd1; n.len = 4'd0; return n; end
        if (s.cur == 4'd1) n = plan(o, f, a, j);
        if (n.len == 4'd0) n.cur = 4'd0;
        else begin
            n.cur = n.seq[3:0];
            n.seq = n.seq >> 4;
            n.len = n.len - 4'd1;
        end
        return n;
    endfunction

    function automatic ctl_t expect_ctl(input logic [3:0] s, input bit mr, input bit rn, input logic [5:0] f);
        ctl_t c = '0;
        bit ok;
        case (s)
            4'd0:  begin c.srcb = 2'b01; c.aluc = 3'b010; c.irw = mr & rn; c.pcw = mr & rn; end
            4'd1:  begin c.srcb = 2'b11; c.aluc = 3'b010; end
            4'd2:  begin c.srca = 1'b1; c.srcb = 2'b10; c.aluc = 3'b010; end
            4'd3:  c.iord = 1'b1;
            4'd4:  begin c.m2r = 1'b1; c.regw = 1'b1; end
            4'd5:  begin c.iord = 1'b1; c.memw = 1'b1; end
            4'd6:  begin c.srca = 1'b1; c.aluc = funct_code(f, ok); end
            4'd7:  begin c.regdst = 1'b1; c.regw = 1'b1; end
            4'd8:  begin c.srca = 1'b1; c.aluc = 3'b110; c.br = 1'b1; c.pcsrc = 2'b01; end
            4'd9:  begin c.srca = 1'b1; c.srcb = 2'b10; c.aluc = 3'b010; end
            4'd10: c.regw = 1'b1;
            4'd11: begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            4'd15: c.ill = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t dut_ctl(input int i);
        return '{iord[i], irw[i], memw[i], pcw[i], br[i], pcsrc[i], srca[i], srcb[i],
                 regdst[i], m2r[i], regw[i], aluc[i], ill[i]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) m[i] <= '0;
            else        m[i] <= mnext(m[i], ea[i], ej[i], op, funct, mem_ready);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("state[%0d]", i), int'(st[i]), int'(m[i].cur));
            chk($sformatf("ctl[%0d]", i), int'(dut_ctl(i)),
                int'(expect_ctl(m[i].cur, mem_ready, rst_n, funct)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lw_seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [5:0] ops [7]    = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111};
    logic [5:0] fns [5]    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        int cnt;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("reset state", int'(st[0]), 0);
        chk("reset IRWrite", int'(irw[0]), 0);
        chk("reset PCWrite", int'(pcw[0]), 0);
        chk("reset illegal", int'(ill[0]), 0);

        // lw with no waits: 0,1,2,3,4,0
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            chk("lw state", int'(st[0]), int'(lw_seq[i]));
            chk("lw RegWrite", int'(regw[0]), (i == 4) ? 1 : 0);
            chk("lw MemtoReg", int'(m2r[0]), (i == 4) ? 1 : 0);
        end

        // sw with three wait cycles in MEMWR
        op = SW;
        step(); chk("sw decode", int'(st[0]), 1);
        step(); chk("sw memadr", int'(st[0]), 2);
        mem_ready = 1'b0;
        step(); chk("sw memwr", int'(st[0]), 5);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (memw[0]) cnt++;
            if (k == 3) mem_ready = 1'b1;
            step();
            if (st[0] == 4'd0) break;
        end
        chk("sw MemWrite cycles", cnt, 4);
        chk("sw back to fetch", int'(st[0]), 0);

        // slt R-type then beq
        op = RT; funct = 6'b101010;
        step(); step();
        chk("slt execute", int'(st[0]), 6);
        chk("slt ALUControl", int'(aluc[0]), 3'b111);
        step();
        chk("slt RegDst", int'(regdst[0]), 1);
        chk("slt RegWrite", int'(regw[0]), 1);
        op = BEQ;
        step(); step(); step();
        chk("beq state", int'(st[0]), 8);
        chk("beq Branch", int'(br[0]), 1);
        chk("beq PCSrc", int'(pcsrc[0]), 2'b01);
        chk("beq ALUControl", int'(aluc[0]), 3'b110);
        step();
        chk("beq to fetch", int'(st[0]), 0);

        // j: legal on dut0, illegal and sticky on dut1
        op = JMP;
        step(); step();
        chk("j state", int'(st[0]), 11);
        chk("j PCSrc", int'(pcsrc[0]), 2'b10);
        chk("j disabled state", int'(st[1]), 15);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("illegal held", int'(ill[1]), 1);
        end
        rst_n = 1'b0;
        #1;
        chk("illegal cleared state", int'(st[1]), 0);
        chk("illegal cleared", int'(ill[1]), 0);
        step();
        rst_n = 1'b1;

        // async reset during MEMRD
        op = LW;
        step(); step();
        mem_ready = 1'b0;
        step(); chk("memrd entered", int'(st[0]), 3);
        step(); chk("memrd waiting", int'(st[0]), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async abort state", int'(st[0]), 0);
        chk("async abort RegWrite", int'(regw[0]), 0);
        mem_ready = 1'b1;
        step();
        chk("reset hold RegWrite", int'(regw[0]), 0);
        chk("reset hold IRWrite", int'(irw[0]), 0);
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m[0].cur == 4'd0) begin
                op = ops[$urandom_range(0, 6)];
                if (op == 6'b111111) op = 6'($urandom);
                funct = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            end
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter EN_ADDI, default 1, meaning addi (Op 001000) is decoded; when 0, addi is treated as an illegal opcode.
REQ-002 SHALL have parameter EN_JUMP, default 1, meaning j (Op 000010) is decoded; when 0, j is treated as an illegal opcode.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 Op  input  6  opcode, held stable by the instruction register from DECODE onward.
REQ-007 Funct  input  6  R-type function code, held stable from DECODE onward.
REQ-008 mem_ready  input  1  memory handshake: the current access completes in this cycle.
REQ-009 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 MemWrite  output  1  memory write request.
REQ-012 PCWrite  output  1  unconditional PC write enable.
REQ-013 Branch  output  1  conditional PC write enable, qualified by the ALU Zero flag.
REQ-014 PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-016 ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-017 RegDst  output  1  destination select: 0 = rt, 1 = rd.
REQ-018 MemtoReg  output  1  write-back select: 0 = ALUOut, 1 = memory data.
REQ-019 RegWrite  output  1  register file write enable.
REQ-020 ALUControl  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-021 illegal  output  1  sticky flag indicating an undecodable instruction.
REQ-022 state  output  4  current FSM state, exported for debug.

Function
REQ-023 SHALL use a Moore FSM with these encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 15; codes 12-14 SHALL go to FETCH on the next edge.
REQ-024 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite=PCWrite=mem_ready; SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-025 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010; next state by Op: lw 100011 or sw 101011 -> MEMADR; R-type 000000 with a listed Funct -> EXECUTE; beq 000100 -> BRANCH; addi (if EN_ADDI) -> ADDIEX; j (if EN_JUMP) -> JUMP; anything else -> ILLEGAL.
REQ-026 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next state is MEMRD for lw and MEMWR for sw.
REQ-027 MEMRD: IorD=1; SHALL wait while mem_ready=0, then go to MEMWB.
REQ-028 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state is FETCH.
REQ-029 MEMWR: IorD=1, MemWrite=1 for every cycle spent in MEMWR; SHALL wait while mem_ready=0, then go to FETCH.
REQ-030 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct (100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111); next state is ALUWB.
REQ-031 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next state is FETCH.
REQ-032 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, Branch=1, PCSrc=01; next state is FETCH.
REQ-033 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next state is ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next state is FETCH.
REQ-034 JUMP: PCWrite=1, PCSrc=10; next state is FETCH.
REQ-035 ILLEGAL: illegal=1, with all write enables 0; SHALL stay in ILLEGAL until reset.
REQ-036 Any output not listed for a state SHALL be 0.
REQ-037 Outputs SHALL depend only on the state, except IRWrite and PCWrite in FETCH, which are gated by mem_ready.
REQ-038 Latency without memory wait states SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Reset
REQ-039 While rst_n=0, state SHALL be FETCH and IRWrite, PCWrite, MemWrite, RegWrite and illegal SHALL be 0 regardless of mem_ready. Asserting rst_n mid-instruction SHALL abort it immediately.
REQ-040 On the first rising edge after rst_n deasserts, normal FETCH behaviour SHALL begin.

Verification
REQ-041 Reset is released with mem_ready=1 and Op=100011 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-042 sw is issued with mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for exactly 4 cycles, then state=0.
REQ-043 R-type with Funct=101010 -> ALUControl=111 in EXECUTE, and RegDst=1, RegWrite=1 in ALUWB.
REQ-044 Op=000100 -> BRANCH state with Branch=1, PCSrc=01, ALUControl=110, then FETCH.
REQ-045 With EN_JUMP=0, Op=000010 -> state=15 and illegal=1 held for 10 cycles; pulsing rst_n low -> state=0 and illegal=0.
REQ-046 rst_n is asserted during MEMRD -> state=0 asynchronously with no RegWrite pulse.
